// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges the ALU and load result streams into
// the single write port, loads first, with a starvation escape for the ALU.

module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  input  logic [4:0]  query_addr,
  output logic        hit
);
  logic [DEPTH-1:0][4:0]  mem_rd;
  logic [DEPTH-1:0][31:0] mem_data;
  logic [AW-1:0]          wptr, rptr, idx;
  logic [AW:0]            count;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = mem_rd[rptr];
  assign head_data = mem_data[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_rd[wptr]   <= push_rd;
        mem_data[wptr] <= push_data;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only occupied slots (counted from the read pointer) can match.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if ((AW+1)'(i) < count && mem_rd[idx] == query_addr) hit = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  busy_addr,
  output logic        busy,
  output logic [4:0]  writereg_addr,
  output logic [31:0] writedata,
  output logic        regwrite
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int NSRC = 2;  // 0 = ALU, 1 = load

  logic [NSRC-1:0]       in_valid, ready, push, pop, full, empty, hit;
  logic [NSRC-1:0][4:0]  in_rd, head_rd;
  logic [NSRC-1:0][31:0] in_data, head_data;
  logic [SW-1:0]         starve_cnt;
  logic                  force_alu;

  assign in_valid = {ld_valid, alu_valid};
  assign in_rd    = {ld_rd, alu_rd};
  assign in_data  = {ld_data, alu_data};

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      assign ready[s] = rst && !full[s];
      // rd==0 consumes the handshake but never occupies a slot
      assign push[s]  = in_valid[s] && ready[s] && (in_rd[s] != 5'd0);
      regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push[s]),
        .push_rd    (in_rd[s]),
        .push_data  (in_data[s]),
        .pop        (pop[s]),
        .head_rd    (head_rd[s]),
        .head_data  (head_data[s]),
        .full       (full[s]),
        .empty      (empty[s]),
        .query_addr (busy_addr),
        .hit        (hit[s])
      );
    end
  endgenerate

  assign alu_ready = ready[0];
  assign ld_ready  = ready[1];

  assign force_alu = (starve_cnt == SW'(STARVE_LIMIT));
  assign pop[1]    = rst && !empty[1] && (empty[0] || !force_alu);
  assign pop[0]    = rst && !empty[0] && (empty[1] || force_alu);

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt    <= '0;
      regwrite      <= 1'b0;
      writereg_addr <= '0;
      writedata     <= '0;
    end else begin
      if (empty[0] || pop[0])        starve_cnt <= '0;
      else if (pop[1] && !force_alu) starve_cnt <= starve_cnt + 1'b1;
      regwrite <= |pop;
      if (|pop) begin
        writereg_addr <= pop[1] ? head_rd[1]   : head_rd[0];
        writedata     <= pop[1] ? head_data[1] : head_data[0];
      end
    end
  end

  assign busy = (busy_addr != 5'd0) &&
                ((|hit) || (regwrite && writereg_addr == busy_addr));
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back side of the register file. Merges two result streams into the register file's single write port (writereg_addr / writedata / regwrite): ALU results and load results returning from data memory with variable latency.
- Each source has a small FIFO with a valid/ready handshake.
- Fixed priority goes to loads, with an anti-starvation counter for the ALU stream.
- Provides a combinational busy query so decode can stall on an outstanding write.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive denied cycles after which the ALU stream is force-granted.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- alu_valid  input  1  ALU result offered.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU FIFO can accept.
- ld_valid  input  1  load result offered.
- ld_rd  input  5  load destination register.
- ld_data  input  32  load data.
- ld_ready  output  1  load FIFO can accept.
- busy_addr  input  5  register number being queried by decode.
- busy  output  1  a write to busy_addr is still queued or in the output stage.
- writereg_addr  output  5  register file write address (registered).
- writedata  output  32  register file write data (registered).
- regwrite  output  1  register file write enable (registered).

Behaviour:
- Reset (rst=0 at a clk edge):
  - Both FIFOs flushed (pointers and counts cleared).
  - Starve counter = 0.
  - regwrite=0, writereg_addr=0, writedata=0.
  - alu_ready=0 and ld_ready=0 while rst=0.
  - A reset asserted mid-operation discards all queued and in-flight writes; none reach the register file.
- Handshake:
  - Transfer occurs on an edge where valid && ready.
  - ready = !full, computed from registered FIFO state only. A pop in the same cycle does not make a full FIFO ready.
- x0 discard: a transfer with rd==0 is accepted (consumes the handshake) but not enqueued.
- Grant, evaluated each edge with FIFO state before the edge:
  - Only the LD FIFO non-empty → pop LD.
  - Only the ALU FIFO non-empty → pop ALU.
  - Both non-empty → pop LD, unless starve_cnt == STARVE_LIMIT, in which case pop ALU.
  - At most one pop per edge.
- Output stage:
  - On a pop edge: writereg_addr/writedata take the popped entry and regwrite=1.
  - On a no-pop edge: regwrite=0 and addr/data hold their last values.
- Latency: an entry accepted at edge E0 into an empty FIFO with no competition is popped at E1. regwrite is high in the cycle after E1. Minimum is 2 edges.
- Starve counter:
  - Increments on an edge where the ALU FIFO is non-empty and LD is granted.
  - Resets to 0 on an ALU grant, or when the ALU FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Simultaneous push and pop on the same FIFO in one edge: both occur and the count is unchanged. An empty FIFO never pops an entry pushed on the same edge.
- Ordering: FIFO order within each source. No ordering guarantee between sources.
- busy (combinational) = 1 when any of these targets busy_addr:
  - any valid ALU FIFO entry,
  - any valid LD FIFO entry,
  - the output stage (regwrite && writereg_addr==busy_addr).
- busy_addr==0 → busy=0.

Test Plan:
- Reset → after the reset edge: regwrite=0, writereg_addr=0, writedata=0, alu_ready=1, ld_ready=1. rst held low with alu_valid=1 → no regwrite ever.
- Single ALU write: alu rd=5, data=0xDEADBEEF at E0 → regwrite=1, addr=5, data=0xDEADBEEF in the cycle after E1 only. busy_addr=5 gives busy=1 from after E0 through that cycle, then 0.
- Concurrent sources: at E0, alu rd=3/0x11 and ld rd=7/0x22 → writes in order x7=0x22, then x3=0x11, on consecutive cycles.
- Starvation:
  - ALU holds one entry while the LD FIFO is refilled every cycle.
  - After 4 LD grants, the ALU entry is written on the 5th grant; LD resumes after.
- Backpressure: ld_valid held 1 with DEPTH=2 and ALU priority forced via starve → ld_ready drops to 0 when 2 entries are queued. No data is lost, and the order of the 3 LD writes matches the input order.
- x0 discard: alu rd=0, data=0xFFFFFFFF → handshake completes, regwrite never asserts, busy_addr=0 gives busy=0.
- Mid-operation reset: with 2 entries queued in each FIFO, pulse rst=0 for one edge → regwrite stays 0 afterwards and busy=0 for all addresses.
